// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if
//   Groups the serial line and the received-byte outputs of uart_rx_core.
//   slave  : the receiver core (samples rx, drives the result signals)
//   master : the line driver / byte consumer side
//   rx         serial line, idle high, asynchronous to clk
//   baud_clk_r one-clk pulse per 16x oversample tick
//   rx_data    last received byte (LSB received first)
//   doner      one-cycle frame-complete strobe
//   error      one-cycle bad-frame strobe, coincident with doner
interface uart_rx_core_if;
  logic       rx;
  logic       baud_clk_r;
  logic [7:0] rx_data;
  logic       doner;
  logic       error;

  modport slave (
    input  rx,
    output baud_clk_r,
    output rx_data,
    output doner,
    output error
  );

  modport master (
    output rx,
    input  baud_clk_r,
    input  rx_data,
    input  doner,
    input  error
  );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   Receive-side UART engine: synchronises rx, oversamples at 16x baud,
//   checks start/stop (and optionally even parity) and presents each byte
//   with a one-cycle doner strobe and a coincident error strobe.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : uart_rx_core_if.slave (rx in; baud_clk_r, rx_data, doner, error out)
// Parameters:
//   CLK_FREQ, BAUD : clock and line rate; TICK_DIV = clk cycles per tick (>=1)
// Build option:
//   UART_RX_PARITY_EN : frame carries an even-parity bit after bit 7 (8E1);
//                       undefined gives 8N1.
module uart_rx_core #(
  parameter int unsigned CLK_FREQ = 40_000_000,
  parameter int unsigned BAUD     = 115_200,
  parameter int unsigned TICK_DIV = CLK_FREQ / (BAUD * 16)
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_core_if.slave  bus
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] TICK_MAX = DIV_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // synchroniser and edge history
  logic             r_sync1;
  logic             r_sync2;
  logic             r_rxs_prev;
  logic             w_rxs;

  // tick generator
  logic [DIV_W-1:0] r_div;
  logic             r_tick_en;
  logic             w_tick;
  logic             w_div_clr;

  // FSM and datapath
  state_t           r_state;
  state_t           w_nstate;
  logic [3:0]       r_tcnt;
  logic [3:0]       w_tcnt_n;
  logic [2:0]       r_bidx;
  logic [2:0]       w_bidx_n;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_n;
  logic [7:0]       r_data;
  logic [7:0]       w_data_n;
  logic             r_done;
  logic             w_done_n;
  logic             r_err;
  logic             w_err_n;
  logic             w_mid;
  logic             w_full;
`ifdef UART_RX_PARITY_EN
  logic             r_par;
  logic             w_par_n;
`endif

  assign w_rxs = r_sync2;

  // r_tick_en keeps the tick (and baud_clk_r) low while and right after
  // reset, which matters when TICK_DIV=1 and the count is always at max.
  assign w_tick = r_tick_en && (r_div == TICK_MAX);
  assign w_mid  = w_tick && (r_tcnt == 4'd7);
  assign w_full = w_tick && (r_tcnt == 4'd15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync1    <= bus.rx;
      r_sync2    <= r_sync1;
      r_rxs_prev <= w_rxs;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div     <= '0;
      r_tick_en <= 1'b0;
    end else begin
      r_tick_en <= 1'b1;
      if (w_div_clr || (r_div == TICK_MAX)) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_bidx  <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_nstate;
      r_tcnt  <= w_tcnt_n;
      r_bidx  <= w_bidx_n;
      r_shift <= w_shift_n;
      r_data  <= w_data_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_n;
`endif
    end
  end

  always_comb begin
    w_nstate  = r_state;
    w_tcnt_n  = w_tick ? (r_tcnt + 4'd1) : r_tcnt;
    w_bidx_n  = r_bidx;
    w_shift_n = r_shift;
    w_data_n  = r_data;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;
    w_div_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_n   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_tcnt_n = '0;
        // falling edge only: a line stuck low is not re-detected
        if (r_rxs_prev && !w_rxs) begin
          w_nstate  = S_START;
          w_div_clr = 1'b1;
        end
      end
      S_START: begin
        if (w_mid) begin
          if (!w_rxs) begin
            w_nstate = S_DATA;
            w_tcnt_n = '0;
            w_bidx_n = '0;
          end else begin
            w_nstate = S_IDLE;
          end
        end
      end
      S_DATA: begin
        // the mid-start alignment means every 16th tick lands mid-bit;
        // tcnt wraps to 0 by itself, keeping the phase for later bits
        if (w_full) begin
          w_shift_n = {w_rxs, r_shift[7:1]};
          w_bidx_n  = r_bidx + 3'd1;
          if (r_bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_nstate = S_PARITY;
`else
            w_nstate = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_full) begin
          w_par_n  = w_rxs;
          w_nstate = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // leave at mid-stop so a back-to-back start edge is not missed
        if (w_full) begin
          w_data_n = r_shift;
          w_done_n = 1'b1;
`ifdef UART_RX_PARITY_EN
          w_err_n  = ~w_rxs | (^{r_shift, r_par});
`else
          w_err_n  = ~w_rxs;
`endif
          w_nstate = S_IDLE;
        end
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase
  end

  assign bus.baud_clk_r = w_tick;
  assign bus.rx_data    = r_data;
  assign bus.doner      = r_done;
  assign bus.error      = r_err;

endmodule
